mult_datapath: RTL and testbench
================================

MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; only 8 is supported and verified.
REQ-002 Parameter BCD_DIGITS, default 5: number of BCD digits, sized to cover 2*WIDTH bits.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port load, input, 1: capture operands and clear the product.
REQ-006 Port enable, input, 1: perform one shift-add step this cycle.
REQ-007 Port Psel, input, 1: add the shifted multiplicand into the product on this step.
REQ-008 Port multiplicand, input, WIDTH: two's-complement operand A.
REQ-009 Port multiplier, input, WIDTH: two's-complement operand B.
REQ-010 Port bcd_start, input, 1: start converting the product magnitude to BCD.
REQ-011 Port z_flag, output, 1: high when the multiplier shift register equals 0.
REQ-012 Port b0, output, 1: bit 0 of the multiplier shift register.
REQ-013 Port product, output, 2*WIDTH: unsigned product magnitude.
REQ-014 Port sign, output, 1: product sign (1 = negative, only when the magnitude is nonzero).
REQ-015 Port bcd, output, 4*BCD_DIGITS: BCD digits of the product, most significant digit first.
REQ-016 Port bcd_busy, output, 1: conversion in progress.
REQ-017 Port bcd_valid, output, 1: bcd holds the result of the last completed conversion.

Function
REQ-018 On load, the block SHALL set M <= zero-extended |A| (2*WIDTH bits), Q <= |B| (WIDTH bits), P <= 0 and sign <= A[msb] XOR B[msb], all visible the next cycle.
REQ-019 Magnitude SHALL be computed as an unsigned WIDTH-bit value, so -128 maps to 128 with no overflow.
REQ-020 On enable without load, the block SHALL update P <= P + M only if Psel is high, and SHALL always shift M <= M << 1 and Q <= Q >> 1.
REQ-021 Product addition SHALL be modulo 2^(2*WIDTH); no overflow is possible for legal operands.
REQ-022 load SHALL take priority over enable in the same cycle.
REQ-023 Psel SHALL be ignored while enable is low.
REQ-024 z_flag and b0 SHALL be combinational from Q, so they are valid in the cycle after load or a step.
REQ-025 enable while z_flag is high SHALL leave P unchanged (Q stays 0; M shifts harmlessly).
REQ-026 The sign output SHALL be forced to 0 when P is 0 and Q is 0.
REQ-027 The BCD converter SHALL be an FSM with states IDLE, SHIFT and DONE.
REQ-028 IDLE->SHIFT on bcd_start: the converter SHALL latch the current P, clear the digits and set the counter to 2*WIDTH.
REQ-029 In SHIFT, each cycle the converter SHALL add 3 to every digit >= 5, then shift left one bit (double-dabble), and decrement the counter.
REQ-030 The FSM SHALL move SHIFT->DONE after exactly 2*WIDTH cycles; bcd_busy SHALL be high for exactly those cycles.
REQ-031 In DONE, bcd_valid SHALL be 1 and bcd stable; bcd_start re-enters SHIFT.
REQ-032 bcd_start SHALL be ignored while in SHIFT.
REQ-033 load SHALL clear bcd_valid and return the FSM to IDLE, aborting any conversion in progress.
REQ-034 Changes to P during SHIFT SHALL not affect the conversion, which uses the latched copy.

Reset
REQ-035 rst SHALL take priority over all other inputs.
REQ-036 rst SHALL clear M, P, Q, sign, bcd, bcd_busy and bcd_valid to 0 and put the FSM in IDLE.
REQ-037 After rst, outputs SHALL be z_flag=1 and b0=0.
REQ-038 rst asserted mid-multiply or mid-conversion SHALL abort the operation with no residual state.

Structure
REQ-039 The FSM state encoding, WIDTH, and BCD_DIGITS defaults SHALL reside in a shared package used by CU and the display stage.
REQ-040 The BCD converter SHALL be a single sub-module, bin2bcd_seq; the shift-add registers SHALL stay in the top module.

Verification
REQ-041 A=5, B=3: load, then steps with Psel=b0 until z_flag=1 -> product=15, sign=0, z_flag high after step 2.
REQ-042 A=-12, B=10: full multiply, then bcd_start -> product=120, sign=1, bcd=0x00120, bcd_busy high 16 cycles, then bcd_valid=1.
REQ-043 A=-128, B=-128 -> product=16384, sign=0, bcd=0x16384.
REQ-044 B=0: load -> z_flag=1 next cycle, b0=0; 3 enables -> product=0, sign=0.
REQ-045 load and enable in the same cycle; second bcd_start at cycle 5 of SHIFT -> load wins with P=0; second start ignored and result completes at cycle 16.
REQ-046 rst pulse at step 3 of a multiply and at cycle 8 of a conversion -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/mult_datapath_pkg.sv
// rtl/mult_datapath_pkg.sv - shared defaults, BCD converter state encoding and digit helper
package mult_datapath_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int BCD_DIGITS_DEF = 5;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_t;

    // Double-dabble correction: a digit of 5..9 would overflow past 9 when doubled
    function automatic logic [3:0] digit_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq
    import mult_datapath_pkg::*;
#(
    parameter int BIN_W      = 2 * WIDTH_DEF,
    parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    busy,
    output logic                    valid
);

    localparam int CW = $clog2(BIN_W + 1);

    bcd_state_t              state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [BIN_W-1:0]        bin_q, bin_nxt;
    logic [4*BCD_DIGITS-1:0] dig_q, dig_nxt, adj;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BCD_IDLE;
            cnt   <= '0;
            bin_q <= '0;
            dig_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bin_q <= bin_nxt;
            dig_q <= dig_nxt;
        end
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj[4*i +: 4] = digit_adjust(dig_q[4*i +: 4]);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bin_nxt   = bin_q;
        dig_nxt   = dig_q;
        case (state)
            BCD_IDLE, BCD_DONE: begin
                if (start) begin
                    state_nxt = BCD_SHIFT;
                    bin_nxt   = bin;
                    dig_nxt   = '0;
                    cnt_nxt   = CW'(BIN_W);
                end
            end
            BCD_SHIFT: begin
                {dig_nxt, bin_nxt} = {adj[4*BCD_DIGITS-2:0], bin_q, 1'b0};
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = BCD_DONE;
                end
            end
            default: state_nxt = BCD_IDLE;
        endcase
        // A new operand load invalidates any result or conversion in flight
        if (clear) begin
            state_nxt = BCD_IDLE;
        end
    end

    assign bcd   = dig_q;
    assign busy  = (state == BCD_SHIFT);
    assign valid = (state == BCD_DONE);

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - sign-magnitude shift-add multiplier datapath with BCD display stage
module mult_datapath
    import mult_datapath_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int BCD_DIGITS = BCD_DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    Psel,
    input  logic [WIDTH-1:0]        multiplicand,
    input  logic [WIDTH-1:0]        multiplier,
    input  logic                    bcd_start,
    output logic                    z_flag,
    output logic                    b0,
    output logic [2*WIDTH-1:0]      product,
    output logic                    sign,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    bcd_busy,
    output logic                    bcd_valid
);

    logic [2*WIDTH-1:0] m_reg, p_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               sign_reg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // Unsigned WIDTH-bit magnitude, so the most negative value maps cleanly
    assign mag_a = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
    assign mag_b = multiplier[WIDTH-1]   ? (~multiplier + WIDTH'(1))   : multiplier;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg    <= '0;
            q_reg    <= '0;
            p_reg    <= '0;
            sign_reg <= 1'b0;
        end else if (load) begin
            m_reg    <= {{WIDTH{1'b0}}, mag_a};
            q_reg    <= mag_b;
            p_reg    <= '0;
            sign_reg <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
        end else if (enable) begin
            if (Psel) begin
                p_reg <= p_reg + m_reg;
            end
            m_reg <= m_reg << 1;
            q_reg <= q_reg >> 1;
        end
    end

    assign z_flag  = (q_reg == '0);
    assign b0      = q_reg[0];
    assign product = p_reg;
    assign sign    = sign_reg & ~((p_reg == '0) && (q_reg == '0));

    bin2bcd_seq #(
        .BIN_W      (2 * WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .clear (load),
        .start (bcd_start),
        .bin   (p_reg),
        .bcd   (bcd),
        .busy  (bcd_busy),
        .valid (bcd_valid)
    );

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - directed self-checking bench for mult_datapath
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        rst, load, enable, Psel, bcd_start;
    logic [7:0]  multiplicand, multiplier;
    logic        z_flag, b0, sign, bcd_busy, bcd_valid;
    logic [15:0] product;
    logic [19:0] bcd;

    int n_vec = 0;
    int n_err = 0;
    int steps;
    int nbusy;

    always #5 clk = ~clk;

    mult_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .enable       (enable),
        .Psel         (Psel),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .bcd_start    (bcd_start),
        .z_flag       (z_flag),
        .b0           (b0),
        .product      (product),
        .sign         (sign),
        .bcd          (bcd),
        .bcd_busy     (bcd_busy),
        .bcd_valid    (bcd_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mul(input logic [7:0] a, input logic [7:0] b, output int nsteps);
        load = 1'b1; multiplicand = a; multiplier = b;
        tick();
        load = 1'b0;
        nsteps = 0;
        while (!z_flag && nsteps < 20) begin
            enable = 1'b1; Psel = b0;
            tick();
            nsteps++;
        end
        enable = 1'b0; Psel = 1'b0;
    endtask

    // poke_at: SHIFT cycle in which a second start plus a product-changing step is applied
    task automatic conv(input int poke_at, output int busy_cycles);
        bcd_start = 1'b1;
        tick();
        bcd_start = 1'b0;
        busy_cycles = 0;
        for (int i = 1; i <= 40 && bcd_busy; i++) begin
            busy_cycles++;
            if (i == poke_at) begin
                bcd_start = 1'b1; enable = 1'b1; Psel = 1'b1;
            end
            tick();
            bcd_start = 1'b0; enable = 1'b0; Psel = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_z"}, z_flag, 1);
        chk({tag, "_b0"}, b0, 0);
        chk({tag, "_prod"}, product, 0);
        chk({tag, "_sign"}, sign, 0);
        chk({tag, "_bcd"}, bcd, 0);
        chk({tag, "_busy"}, bcd_busy, 0);
        chk({tag, "_valid"}, bcd_valid, 0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; enable = 1'b0; Psel = 1'b0; bcd_start = 1'b0;
        multiplicand = 8'd0; multiplier = 8'd0;
        tick(); tick();
        rst = 1'b0;
        chk_reset_state("reset");

        // 5 x 3
        load = 1'b1; multiplicand = 8'd5; multiplier = 8'd3;
        tick();
        load = 1'b0;
        chk("5x3_load_z", z_flag, 0);
        chk("5x3_load_b0", b0, 1);
        enable = 1'b1; Psel = b0; tick();
        chk("5x3_step1_prod", product, 5);
        chk("5x3_step1_z", z_flag, 0);
        Psel = b0; tick();
        enable = 1'b0; Psel = 1'b0;
        chk("5x3_step2_z", z_flag, 1);
        chk("5x3_prod", product, 15);
        chk("5x3_sign", sign, 0);

        // -12 x 10 with conversion
        mul(8'hF4, 8'd10, steps);
        chk("m12x10_steps", steps, 4);
        chk("m12x10_prod", product, 120);
        chk("m12x10_sign", sign, 1);
        conv(0, nbusy);
        chk("m12x10_busy_cycles", nbusy, 16);
        chk("m12x10_valid", bcd_valid, 1);
        chk("m12x10_bcd", bcd, 20'h00120);
        tick();
        chk("m12x10_bcd_stable", bcd, 20'h00120);

        // -128 x -128
        mul(8'h80, 8'h80, steps);
        chk("m128_valid_cleared", bcd_valid, 0);
        chk("m128_steps", steps, 8);
        chk("m128_prod", product, 16384);
        chk("m128_sign", sign, 0);
        conv(0, nbusy);
        chk("m128_busy_cycles", nbusy, 16);
        chk("m128_bcd", bcd, 20'h16384);

        // B = 0 with negative A: sign forced low
        load = 1'b1; multiplicand = 8'hF9; multiplier = 8'd0;
        tick();
        load = 1'b0;
        chk("b0_load_z", z_flag, 1);
        chk("b0_load_b0", b0, 0);
        for (int i = 0; i < 3; i++) begin
            enable = 1'b1; Psel = b0; tick();
        end
        enable = 1'b0; Psel = 1'b0;
        chk("bzero_prod", product, 0);
        chk("bzero_sign", sign, 0);

        // Second start at SHIFT cycle 5 is ignored; P changes mid-conversion
        mul(8'd5, 8'd3, steps);
        chk("redo_prod", product, 15);
        conv(5, nbusy);
        chk("restart_busy_cycles", nbusy, 16);
        chk("restart_valid", bcd_valid, 1);
        chk("restart_bcd_latched", bcd, 20'h00015);
        chk("restart_prod_moved", product, 35);

        // load with enable during a conversion: load wins and aborts
        conv(0, nbusy);
        bcd_start = 1'b1; tick(); bcd_start = 1'b0;
        tick(); tick();
        load = 1'b1; enable = 1'b1; Psel = 1'b1;
        multiplicand = 8'd3; multiplier = 8'd2;
        tick();
        load = 1'b0; enable = 1'b0; Psel = 1'b0;
        chk("ldwin_prod", product, 0);
        chk("ldwin_b0", b0, 0);
        chk("ldwin_z", z_flag, 0);
        chk("ldwin_busy", bcd_busy, 0);
        chk("ldwin_valid", bcd_valid, 0);

        // rst at step 3 of a multiply
        load = 1'b1; multiplicand = 8'hF4; multiplier = 8'd10;
        tick();
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enable = 1'b1; Psel = b0; tick();
        end
        rst = 1'b1; enable = 1'b1; Psel = 1'b1;
        tick();
        rst = 1'b0; enable = 1'b0; Psel = 1'b0;
        chk_reset_state("rst_mul");

        // rst at cycle 8 of a conversion
        mul(8'hF4, 8'd10, steps);
        bcd_start = 1'b1; tick(); bcd_start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("rst_conv_busy_before", bcd_busy, 1);
        rst = 1'b1; bcd_start = 1'b1;
        tick();
        rst = 1'b0; bcd_start = 1'b0;
        chk_reset_state("rst_conv");
        tick(); tick();
        chk("rst_conv_stays_idle", bcd_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
